serial_bit_feeder: RTL
======================

Name: serial_bit_feeder

Overview:
- Upstream stage of the serial sequence-detector FSM: converts parallel words into the single-bit stream that drives the FSM's x_i input.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Shifts the word out one bit at a time, holding each bit for DIV clock cycles.
- Optionally inserts idle gap bits between words and can append a parity bit.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- DIV, 4, clock cycles each bit is held on x_o (>=1).
- GAP_BITS, 1, idle bit periods (x_o=0) inserted after each word (>=0).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.

Ports:
- clk_i, input, 1, system clock; all logic on the rising edge.
- rst_i, input, 1, synchronous, active-high reset.
- data_i, input, DATA_W, parallel word to serialize.
- valid_i, input, 1, data_i holds a valid word.
- ready_o, output, 1, feeder can accept a word this cycle.
- x_o, output, 1, serial bit stream to the FSM's x_i.
- bit_stb_o, output, 1, one-cycle pulse in the first cycle of each data (or parity) bit period.
- busy_o, output, 1, a word is being shifted or a gap is running.
- word_done_o, output, 1, one-cycle pulse when a word (plus parity, if enabled) is finished.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at a rising edge):
  - state=IDLE, shift register=0, counters=0.
  - ready_o=1, x_o=0, bit_stb_o=0, busy_o=0, word_done_o=0.
- All outputs are registered except ready_o, which decodes directly from state.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready_o=1, x_o=0, busy_o=0.
  - valid_i=1 at an edge: latch data_i, go to SHIFT.
  - In the next cycle, x_o = first bit (data_i[DATA_W-1] if MSB_FIRST, else data_i[0]), bit_stb_o=1, busy_o=1.
- SHIFT:
  - ready_o=0; valid_i is ignored and data_i is not sampled.
  - A prescaler counts 0..DIV-1. Each bit is held exactly DIV cycles.
  - When the prescaler reaches DIV-1: the next bit is presented, the prescaler returns to 0, and bit_stb_o pulses.
  - A bit counter counts 0..DATA_W-1.
  - After the last bit's DIV cycles:
    - x_o=0 and word_done_o pulses for one cycle.
    - If GAP_BITS>0, go to GAP; otherwise go to IDLE.
- GAP:
  - x_o=0, busy_o=1, ready_o=0, for GAP_BITS*DIV cycles, then IDLE.
  - bit_stb_o does not pulse during the gap.
- Timing:
  - Accept to word_done_o pulse = DATA_W*DIV+1 cycles.
  - Back-to-back throughput = DATA_W*DIV + GAP_BITS*DIV + 1 cycles per word (one IDLE cycle minimum).
- Boundaries:
  - DIV=1: a new bit every cycle and bit_stb_o is high for DATA_W consecutive cycles.
  - valid_i held high: words are accepted in every IDLE cycle.
  - valid_i deasserting during SHIFT has no effect.
  - rst_i mid-word or mid-gap: the word is dropped, all outputs take reset values at that edge, and no word_done_o is produced.
  - rst_i and valid_i together: reset wins and the word is not accepted.
- Widths:
  - Prescaler width $clog2(DIV) (minimum 1).
  - Bit counter width $clog2(DATA_W+1).
  - Gap counter sized for GAP_BITS*DIV.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - After the last data bit, one extra bit period carries even parity (XOR of all DATA_W bits of the latched word).
  - The parity period lasts DIV cycles and bit_stb_o pulses at its start.
  - word_done_o pulses after the parity period.
  - Accept to done = (DATA_W+1)*DIV+1 cycles.
- Undefined: no parity period; timing exactly as in Behaviour.

Test Plan:
- Reset: assert rst_i 2 cycles with valid_i=1 -> ready_o=1, x_o=0, busy_o=0, word_done_o=0; no word accepted.
- Default params, accept 8'hA5 -> x_o = 1,0,1,0,0,1,0,1, each bit held 4 cycles; 8 bit_stb_o pulses spaced 4 cycles apart; word_done_o at cycle 33 after accept; then 4 gap cycles with x_o=0; ready_o=1 at cycle 37.
- valid_i held high with 8'hFF then 8'h00 -> second word accepted only in the IDLE cycle after the gap; x_o=1 for 32 cycles, 0 for 4 gap cycles, then 0 for 32 cycles.
- rst_i pulsed after the 3rd bit of 8'hC3 -> outputs reset at that edge; no word_done_o; the next word shifts correctly from bit 0.
- MSB_FIRST=0, DIV=1, GAP_BITS=0, word 8'h01 -> x_o = 1,0,0,0,0,0,0,0 on consecutive cycles; bit_stb_o high 8 cycles; word_done_o at cycle 9.
- SERIAL_FEEDER_PARITY_EN defined, word 8'h07 -> after the 8 data bits, a parity bit of 1 held 4 cycles with a bit_stb_o pulse; word_done_o at cycle 37. Word 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_feeder
// Brief    : Serializes DATA_W-bit words into a bit stream. Each bit is held
//            for DIV clocks, and GAP_BITS idle periods follow each word.
//            Optional macro SERIAL_FEEDER_PARITY_EN appends an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int GAP_BITS  = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              x_o,
    output logic              bit_stb_o,
    output logic              busy_o,
    output logic              word_done_o
);

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int c_PAR_BITS = 1;
`else
    localparam int c_PAR_BITS = 0;
`endif
    localparam int c_NBITS    = DATA_W + c_PAR_BITS;
    localparam int c_PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BW       = $clog2(DATA_W + 1);
    localparam int c_GAP_LEN  = GAP_BITS * DIV;
    localparam int c_GW       = (c_GAP_LEN > 1) ? $clog2(c_GAP_LEN) : 1;
    localparam int c_GAP_LAST = (c_GAP_LEN > 0) ? c_GAP_LEN - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [c_PW-1:0]   r_presc;
    logic [c_BW-1:0]   r_bitcnt;
    logic [c_GW-1:0]   r_gapcnt;
    logic              r_x;
    logic              r_stb;
    logic              r_busy;
    logic              r_done;

    logic              w_first_bit;
    logic              w_next_bit;
    logic              w_adv_bit;
    logic [DATA_W-1:0] w_load_shift;
    logic [DATA_W-1:0] w_adv_shift;

    // The shift register holds only the bits not yet presented on x_o.
    assign w_first_bit  = (MSB_FIRST != 0) ? data_i[DATA_W-1]  : data_i[0];
    assign w_load_shift = (MSB_FIRST != 0) ? (data_i << 1)     : (data_i >> 1);
    assign w_next_bit   = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];
    assign w_adv_shift  = (MSB_FIRST != 0) ? (r_shift << 1)    : (r_shift >> 1);

`ifdef SERIAL_FEEDER_PARITY_EN
    logic r_par;
    assign w_adv_bit = (r_bitcnt == c_BW'(DATA_W - 1)) ? r_par : w_next_bit;
`else
    assign w_adv_bit = w_next_bit;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_presc  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_x      <= 1'b0;
            r_stb    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_stb  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_state  <= ST_SHIFT;
                        r_shift  <= w_load_shift;
                        r_presc  <= '0;
                        r_bitcnt <= '0;
                        r_x      <= w_first_bit;
                        r_stb    <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
                        r_par    <= ^data_i;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (r_presc == c_PW'(DIV - 1)) begin
                        r_presc <= '0;
                        if (r_bitcnt == c_BW'(c_NBITS - 1)) begin
                            r_x      <= 1'b0;
                            r_done   <= 1'b1;
                            r_gapcnt <= '0;
                            // The word_done cycle already counts as the first gap cycle.
                            if (c_GAP_LEN > 0) begin
                                r_state <= ST_GAP;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_shift  <= w_adv_shift;
                            r_x      <= w_adv_bit;
                            r_stb    <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gapcnt == c_GW'(c_GAP_LAST)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_gapcnt <= '0;
                    end else begin
                        r_gapcnt <= r_gapcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o     = (r_state == ST_IDLE);
    assign x_o         = r_x;
    assign bit_stb_o   = r_stb;
    assign busy_o      = r_busy;
    assign word_done_o = r_done;

endmodule
`default_nettype wire
